pacman_controller: RTL

Frame-rate motion and game-state controller for the Pac-Man sprite; the direct upstream source of the `pacmanX`/`pacmanY`, `last_keypress`, `closePacman` and `death` signals that `color_mapper` consumes.
- Once per frame it probes the maze through the shared `check_wall` lookup and picks a legal direction from the keyboard.
- It then steps the sprite, animates the mouth and latches ghost collision.

---
 rtl/pacman_pkg.sv | 82 ++++++++
 rtl/pacman_controller_sprite_overlap.sv | 18 +
 rtl/pacman_controller.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pacman_pkg.sv
// Shared types and maze/probe helpers for the Pac-Man controller.
// dir_t encoding is also consumed by color_mapper.
package pacman_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_UP    = 2'd3
  } dir_t;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ_A  = 3'd1;
  localparam logic [2:0] S_REQ_B  = 3'd2;
  localparam logic [2:0] S_CUR_A  = 3'd3;
  localparam logic [2:0] S_CUR_B  = 3'd4;
  localparam logic [2:0] S_UPDATE = 3'd5;
  localparam logic [2:0] S_CHECK  = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_REQ_A  = S_REQ_A,
    ST_REQ_B  = S_REQ_B,
    ST_CUR_A  = S_CUR_A,
    ST_CUR_B  = S_CUR_B,
    ST_UPDATE = S_UPDATE,
    ST_CHECK  = S_CHECK
  } state_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  localparam logic [9:0] SCREEN_W = 10'd640;
  localparam logic [9:0] SCREEN_H = 10'd480;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } point_t;

  function automatic dir_t decode_key(input logic [7:0] key, input dir_t cur);
    case (key)
      KEY_D:   return DIR_RIGHT;
      KEY_S:   return DIR_DOWN;
      KEY_A:   return DIR_LEFT;
      KEY_W:   return DIR_UP;
      default: return cur;
    endcase
  endfunction

  // Leading-edge corner of the sprite for direction d; second selects the far corner.
  // Left/up rely on 10-bit wrap (0-1 = 1023) so the screen-bound check catches them.
  function automatic point_t probe_point(input dir_t d, input point_t p,
                                         input logic second, input logic [9:0] sz);
    point_t     r;
    logic [9:0] off;
    off = second ? sz - 10'd1 : 10'd0;
    r   = p;
    case (d)
      DIR_RIGHT: begin r.x = p.x + sz;     r.y = p.y + off;    end
      DIR_DOWN:  begin r.x = p.x + off;    r.y = p.y + sz;     end
      DIR_LEFT:  begin r.x = p.x - 10'd1;  r.y = p.y + off;    end
      default:   begin r.x = p.x + off;    r.y = p.y - 10'd1;  end
    endcase
    return r;
  endfunction

  function automatic point_t step(input dir_t d, input point_t p);
    point_t r;
    r = p;
    case (d)
      DIR_RIGHT: r.x = p.x + 10'd1;
      DIR_DOWN:  r.y = p.y + 10'd1;
      DIR_LEFT:  r.x = p.x - 10'd1;
      default:   r.y = p.y - 10'd1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pacman_controller_sprite_overlap.sv
// Bounding-box overlap test between two SPRITE x SPRITE sprites given their top-left corners.
module sprite_overlap #(
  parameter int SPRITE = 8
) (
  input  logic [9:0] ax,
  input  logic [9:0] ay,
  input  logic [9:0] bx,
  input  logic [9:0] by,
  output logic       overlap
);
  localparam logic signed [10:0] S = 11'(SPRITE);

  logic signed [10:0] dx, dy;

  assign dx = $signed({1'b0, bx}) - $signed({1'b0, ax});
  assign dy = $signed({1'b0, by}) - $signed({1'b0, ay});
  assign overlap = (dx > -S) && (dx < S) && (dy > -S) && (dy < S);
endmodule

// File: rtl/pacman_controller.sv
// Frame-rate Pac-Man motion/game-state controller: probes walls via check_wall,
// steps the sprite, animates the mouth and latches ghost collision.
module pacman_controller
  import pacman_pkg::*;
#(
  parameter logic [9:0] START_X      = 10'd312,
  parameter logic [9:0] START_Y      = 10'd232,
  parameter int         MOUTH_FRAMES = 8,
  parameter int         SPRITE       = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       wall_hit,
  input  logic [9:0] ghost_redX,
  input  logic [9:0] ghost_redY,
  input  logic [9:0] ghost_greenX,
  input  logic [9:0] ghost_greenY,
  input  logic [9:0] ghost_aquaX,
  input  logic [9:0] ghost_aquaY,
  output logic [9:0] probe_x,
  output logic [9:0] probe_y,
  output logic [9:0] pacmanX,
  output logic [9:0] pacmanY,
  output logic [1:0] last_keypress,
  output logic       closePacman,
  output logic       death
);
  localparam logic [9:0]    SZ         = 10'(SPRITE);
  localparam int            CW         = (MOUTH_FRAMES > 1) ? $clog2(MOUTH_FRAMES) : 1;
  localparam logic [CW-1:0] MOUTH_LAST = CW'(MOUTH_FRAMES - 1);

  state_t        state;
  dir_t          dir, req;
  point_t        pos, probe;
  logic          frame_clk_d, armed, frame_edge, hit;
  logic          req_wall, cur_wall;
  logic [CW-1:0] mouth_cnt;
  logic [2:0][9:0] gx, gy;
  logic [2:0]      ghost_ov;

  assign pacmanX       = pos.x;
  assign pacmanY       = pos.y;
  assign last_keypress = dir;
  assign probe_x       = probe.x;
  assign probe_y       = probe.y;

  // armed blocks the spurious edge when frame_clk is already high as reset releases
  assign frame_edge = frame_clk & ~frame_clk_d & armed;

  always_comb begin
    probe = pos;
    case (state)
      ST_REQ_A: probe = probe_point(req, pos, 1'b0, SZ);
      ST_REQ_B: probe = probe_point(req, pos, 1'b1, SZ);
      ST_CUR_A: probe = probe_point(dir, pos, 1'b0, SZ);
      ST_CUR_B: probe = probe_point(dir, pos, 1'b1, SZ);
      default:  probe = pos;
    endcase
  end

  assign hit = wall_hit | (probe.x >= SCREEN_W) | (probe.y >= SCREEN_H);

  assign gx = {ghost_aquaX, ghost_greenX, ghost_redX};
  assign gy = {ghost_aquaY, ghost_greenY, ghost_redY};

  for (genvar g = 0; g < 3; g++) begin : g_ghost
    sprite_overlap #(.SPRITE(SPRITE)) u_ov (
      .ax      (pos.x),
      .ay      (pos.y),
      .bx      (gx[g]),
      .by      (gy[g]),
      .overlap (ghost_ov[g])
    );
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= ST_IDLE;
      dir         <= DIR_RIGHT;
      req         <= DIR_RIGHT;
      pos         <= '{x: START_X, y: START_Y};
      frame_clk_d <= 1'b0;
      armed       <= 1'b0;
      req_wall    <= 1'b0;
      cur_wall    <= 1'b0;
      mouth_cnt   <= '0;
      closePacman <= 1'b0;
      death       <= 1'b0;
    end else begin
      frame_clk_d <= frame_clk;
      if (!frame_clk) armed <= 1'b1;
      case (state)
        ST_IDLE: if (frame_edge) begin
          req   <= decode_key(keycode, dir);
          state <= ST_REQ_A;
        end
        ST_REQ_A: begin req_wall <= hit;            state <= ST_REQ_B;  end
        ST_REQ_B: begin req_wall <= req_wall | hit; state <= ST_CUR_A;  end
        ST_CUR_A: begin cur_wall <= hit;            state <= ST_CUR_B;  end
        ST_CUR_B: begin cur_wall <= cur_wall | hit; state <= ST_UPDATE; end
        ST_UPDATE: begin
          if (!death && (!req_wall || !cur_wall)) begin
            if (!req_wall) begin
              dir <= req;
              pos <= step(req, pos);
            end else begin
              pos <= step(dir, pos);
            end
            if (mouth_cnt == MOUTH_LAST) begin
              mouth_cnt   <= '0;
              closePacman <= ~closePacman;
            end else begin
              mouth_cnt <= mouth_cnt + 1'b1;
            end
          end
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (|ghost_ov) death <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
